mcpu_ctrl: RTL

Multi-cycle MIPS control unit for the multi-cycle CPU datapath. A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and write enable, including `reg_dst`, the select of the 5-bit register-destination mux (1 = rd, 0 = rt). It also waits on a single-ported memory through a ready handshake.

---
 rtl/mcpu_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_ctrl.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl: control unit for a multi-cycle MIPS datapath.
//
// A Moore FSM steps each instruction through FETCH, DECODE and then an
// opcode-specific execute, memory and writeback path. The datapath selects
// and write enables are decoded combinationally from the current state. Only
// the memory handshake (mem_ready), the branch flag (zero) and, in I_EXE, the
// opcode add to that decode.
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   opcode, funct  : IR[31:26] / IR[5:0]. funct is only decoded outside
//                    this block.
//   zero           : ALU zero flag, used by beq
//   mem_ready      : the single-ported memory completes the access this cycle
//   pc_we, ir_we, reg_we, mem_read, mem_write : enables / memory request
//   iord           : memory address select (0 PC, 1 ALUOut)
//   reg_dst        : destination register select (1 rd, 0 rt)
//   mem_to_reg     : writeback select (1 MDR, 0 ALUOut)
//   alu_src_a      : ALU A select (0 PC, 1 A)
//   alu_src_b      : ALU B select (00 B, 01 4, 10 ext(imm), 11 sext(imm)<<2)
//   alu_op         : 00 add, 01 sub, 10 funct, 11 or
//   ext_zero       : 1 zero-extend imm, 0 sign-extend
//   pc_source      : 00 ALU result, 01 ALUOut, 10 jump target
//   instr_done     : final cycle of every instruction
//   illegal        : unsupported opcode seen in DECODE
//   state          : current state encoding, for debug
// ---------------------------------------------------------------------------
module mcpu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t cur;

  // funct only feeds the external ALU decoder. It is reduced here so that the
  // port stays visible without being left dangling.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign state = cur;

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      cur <= S_R_EXE;
            OP_LW, OP_SW:  cur <= S_MEM_ADDR;
            OP_BEQ:        cur <= S_BRANCH;
            OP_J:          cur <= S_JUMP;
            OP_ADDI, OP_ORI: cur <= S_I_EXE;
            default:       cur <= S_FETCH;  // illegal: retire and refetch
          endcase
        end
        S_MEM_ADDR: cur <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WB:   cur <= S_FETCH;
        S_MEM_WR:   if (mem_ready) cur <= S_FETCH;
        S_R_EXE:    cur <= S_R_WB;
        S_R_WB:     cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        S_JUMP:     cur <= S_FETCH;
        S_I_EXE:    cur <= S_I_WB;
        S_I_WB:     cur <= S_FETCH;
        default:    cur <= S_FETCH;  // unused encodings recover to FETCH
      endcase
    end
  end

  // The output decode is gated by rst_n. While reset is held, nothing reaches
  // the datapath, including the FETCH memory request that the state alone
  // would imply. A reset mid-access therefore drops the request at once.
  // NOTE: every output is defaulted before the case so that states which do
  // not mention a signal drive 0 rather than inferring a latch.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    ext_zero   = 1'b0;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          // PC+4 is computed every FETCH cycle. It is only committed, with
          // the instruction word, in the cycle the memory delivers.
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_we     = mem_ready;
          ir_we     = mem_ready;
        end
        S_DECODE: begin
          // The branch target is computed here, before the opcode is known.
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: ;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_we     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_source  = 2'b01;
          pc_we      = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
        S_I_EXE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          // Only addi and ori reach this state. ori is a logical op on a
          // zero-extended immediate.
          if (opcode == OP_ORI) begin
            alu_op   = 2'b11;
            ext_zero = 1'b1;
          end
        end
        S_I_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
